// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: iterative double-dabble converter, one shift per clock,
// result held in registered BCD digits until the next conversion completes.
module bin2bcd_seq #(
    parameter int IN_W = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [IN_W-1:0] bin_in,
    output logic            busy,
    output logic            done,
    output logic [3:0]      hundred,
    output logic [3:0]      ten,
    output logic [3:0]      one
);
    localparam int CW = $clog2(IN_W + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t          state_q, state_d;
    logic [IN_W-1:0] bin_q, bin_d;
    logic [11:0]     bcd_q, bcd_d, adj;
    logic [11:0]     dig_q, dig_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    always_comb begin
        for (int k = 0; k < 3; k++)
            adj[4*k +: 4] = (bcd_q[4*k +: 4] >= 4'd5) ? bcd_q[4*k +: 4] + 4'd3 : bcd_q[4*k +: 4];
    end

    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        dig_d   = dig_q;
        case (state_q)
            IDLE: if (start) begin
                state_d = SHIFT;
                bin_d   = bin_in;
                bcd_d   = '0;
                cnt_d   = CW'(IN_W);
            end
            SHIFT: begin
                bcd_d = {adj[10:0], bin_q[IN_W-1]};
                bin_d = bin_q << 1;
                cnt_d = cnt_q - CW'(1);
                // digits load only on the final shift so the display never sees partials
                if (cnt_q == CW'(1)) begin
                    state_d = DONE;
                    dig_d   = bcd_d;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            bin_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            dig_q   <= '0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            dig_q   <= dig_d;
        end
    end

    assign busy = state_q != IDLE;
    assign done = state_q == DONE;
    assign {hundred, ten, one} = dig_q;
endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: randomized + directed scoreboard bench; a cycle-level
// reference model pushes expected digits on acceptance, a monitor pops on done.
module tb_bin2bcd_seq;
    localparam int IN_W = 8;
    localparam int W9   = 9;

    logic            clk = 0;
    logic            reset = 1;
    logic            start = 0;
    logic [IN_W-1:0] bin_in = '0;
    logic            busy, done;
    logic [3:0]      hundred, ten, one;

    logic            start9 = 0;
    logic [W9-1:0]   bin9 = '0;
    logic            busy9, done9;
    logic [3:0]      h9, t9, o9;

    int vectors = 0;
    int miscompares = 0;

    typedef struct { int cyc; int h; int t; int o; } exp_t;
    exp_t q[$];

    int cyc = 0;
    int acc = 0;
    bit active = 0;
    bit armed = 0;
    int last_h = 0, last_t = 0, last_o = 0;

    bin2bcd_seq #(.IN_W(IN_W)) dut (
        .clk(clk), .reset(reset), .start(start), .bin_in(bin_in),
        .busy(busy), .done(done), .hundred(hundred), .ten(ten), .one(one)
    );

    bin2bcd_seq #(.IN_W(W9)) dut9 (
        .clk(clk), .reset(reset), .start(start9), .bin_in(bin9),
        .busy(busy9), .done(done9), .hundred(h9), .ten(t9), .one(o9)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    // Reference model: tracks acceptance purely from timing rules, decimal digits by arithmetic
    always @(posedge clk) begin
        cyc++;
        if (reset) begin
            armed  = 1;
            active = 0;
            q.delete();
            last_h = 0; last_t = 0; last_o = 0;
        end else if (start && (!active || cyc >= acc + IN_W + 2)) begin
            acc    = cyc;
            active = 1;
            q.push_back('{cyc, int'(bin_in) / 100, (int'(bin_in) / 10) % 10, int'(bin_in) % 10});
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (armed) begin
            chk("busy", busy, int'(active && cyc >= acc && cyc <= acc + IN_W));
            chk("done", done, int'(active && cyc == acc + IN_W));
            if (done) begin
                if (q.size() == 0) begin
                    chk("spurious_done", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("latency", cyc - e.cyc, IN_W);
                    last_h = e.h; last_t = e.t; last_o = e.o;
                end
            end
            chk("hundred", hundred, last_h);
            chk("ten", ten, last_t);
            chk("one", one, last_o);
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic conv(input int v, input int gap);
        start = 1; bin_in = IN_W'(v);
        tick();
        start = 0; bin_in = IN_W'($urandom);
        repeat (IN_W + 1 + gap) tick();
    endtask

    task automatic conv9(input int v);
        int k = 0;
        start9 = 1; bin9 = W9'(v);
        tick();
        start9 = 0; bin9 = W9'($urandom);
        while (!done9 && k < 20) begin
            tick();
            k++;
        end
        chk("lat9", k, W9);
        chk("h9", h9, v / 100);
        chk("t9", t9, (v / 10) % 10);
        chk("o9", o9, v % 10);
        tick();
        chk("busy9_idle", busy9, 0);
    endtask

    initial begin
        int v, guard, g;
        repeat (2) tick();
        reset = 0;
        tick();
        conv(255, 0);
        conv(0, 1);
        conv(99, 0);
        conv(100, 2);
        // extra start mid-conversion is ignored
        start = 1; bin_in = 128;
        tick();
        start = 0;
        repeat (2) tick();
        start = 1; bin_in = 7;
        tick();
        start = 0;
        repeat (IN_W + 4) tick();
        // reset aborts a conversion
        start = 1; bin_in = 200;
        tick();
        start = 0;
        repeat (3) tick();
        reset = 1;
        tick();
        reset = 0;
        repeat (IN_W + 2) tick();
        conv(45, 1);
        // start held high, bin_in stepping on every acceptance
        v = 0; guard = 0;
        start = 1; bin_in = 0;
        while (v <= 255 && guard < 3000) begin
            tick();
            guard++;
            if (active && acc == cyc) begin
                v++;
                if (v <= 255) bin_in = IN_W'(v);
            end
        end
        start = 0;
        chk("held_start_count", v, 256);
        repeat (IN_W + 3) tick();
        // random conversions with noisy start/bin_in while busy
        for (int n = 0; n < 60; n++) begin
            start = 1; bin_in = IN_W'($urandom);
            tick();
            g = $urandom_range(0, 3);
            for (int i = 0; i < IN_W + 1 + g; i++) begin
                start  = ($urandom_range(0, 3) == 0);
                bin_in = IN_W'($urandom);
                tick();
            end
            start = 0;
            if ($urandom_range(0, 9) == 0) begin
                reset = 1;
                tick();
                reset = 0;
            end
            repeat (IN_W + 2) tick();
        end
        conv9(511);
        conv9(0);
        conv9(300);
        conv9($urandom_range(0, 511));
        repeat (IN_W + 4) tick();
        chk("drain", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
